egress_arbiter: RTL and testbench

Round-robin drain stage directly downstream of `route`. It pops words from the two routing FIFOs through `read0`/`read1` and merges them into one 8-bit egress stream tagged with the source FIFO. A per-grant burst limit keeps one FIFO from starving the other, and a downstream pause throttles read issue.

---
 rtl/routing_pkg.sv | 24 ++
 rtl/egress_capture.sv | 39 +++
 rtl/egress_arbiter.sv | 99 +++++++++
 tb/tb_egress_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/routing_pkg.sv
// Shared routing/egress definitions: arbiter FSM encoding, default widths, grant codes.
// Pure declarations, no timing or backpressure of its own.
package routing_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int BURST_DEF  = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SERVE0 = 2'd1,
      ST_SERVE1 = 2'd2
   } arb_state_t;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_0    = 2'b01;
   localparam logic [1:0] GRANT_1    = 2'b10;

   function automatic arb_state_t serve_state(input logic sel);
      return sel ? ST_SERVE1 : ST_SERVE0;
   endfunction

   function automatic logic [1:0] serve_grant(input logic sel);
      return sel ? GRANT_1 : GRANT_0;
   endfunction
endpackage

// File: rtl/egress_capture.sv
// Read-latency pipeline: read issue/source registered, then FIFO data captured; 2 cycles read->out_valid.
// No backpressure; outputs hold their last word while out_valid is low.
module egress_capture
   import routing_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd,
   input  logic              src,
   input  logic [DATA_W-1:0] fifo0_data,
   input  logic [DATA_W-1:0] fifo1_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_src,
   output logic              out_valid
);
   logic rd_d;
   logic src_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_d      <= 1'b0;
         src_d     <= 1'b0;
         out_data  <= '0;
         out_src   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         rd_d      <= rd;
         src_d     <= src;
         out_valid <= rd_d;
         // FIFO read data is valid the cycle after the pop
         if (rd_d) begin
            out_data <= src_d ? fifo1_data : fifo0_data;
            out_src  <= src_d;
         end
      end
   end
endmodule

// File: rtl/egress_arbiter.sv
// Round-robin drain of two routing FIFOs with per-grant burst limit; read->out_valid is 2 cycles.
// egress_pause blocks read issue in the same cycle and ends the current grant.
module egress_arbiter
   import routing_pkg::*;
#(
   parameter int BURST  = BURST_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] fifo0_data,
   input  logic              fifo0_empty,
   input  logic [DATA_W-1:0] fifo1_data,
   input  logic              fifo1_empty,
   input  logic              egress_pause,
   output logic              read0,
   output logic              read1,
   output logic [DATA_W-1:0] out_data,
   output logic              out_src,
   output logic              out_valid,
   output logic [1:0]        grant
);
   arb_state_t state;
   logic       last_served;
   logic [3:0] burst_cnt;
   logic       cur_sel;
   logic       cur_empty;
   logic       oth_empty;
   logic       rd_issue;
   logic       grant_end;
   logic       enter_vld;
   logic       enter_sel;
   logic       go_idle;

   assign read0     = (state == ST_SERVE0) && !fifo0_empty && !egress_pause;
   assign read1     = (state == ST_SERVE1) && !fifo1_empty && !egress_pause;
   assign rd_issue  = read0 | read1;
   assign cur_sel   = (state == ST_SERVE1);
   assign cur_empty = cur_sel ? fifo1_empty : fifo0_empty;
   assign oth_empty = cur_sel ? fifo0_empty : fifo1_empty;
   assign grant_end = (state != ST_IDLE) &&
                      ((rd_issue && (burst_cnt == 4'(BURST - 1))) || cur_empty || egress_pause);

   always_comb begin
      enter_vld = 1'b0;
      enter_sel = 1'b0;
      go_idle   = 1'b0;
      if (state == ST_IDLE) begin
         if (!egress_pause && !(fifo0_empty && fifo1_empty)) begin
            enter_vld = 1'b1;
            enter_sel = fifo0_empty ? 1'b1 : (fifo1_empty ? 1'b0 : !last_served);
         end
      end else if (grant_end) begin
         // hand over to the other FIFO first so neither can starve
         if (egress_pause) begin
            go_idle = 1'b1;
         end else if (!oth_empty) begin
            enter_vld = 1'b1;
            enter_sel = !cur_sel;
         end else if (!cur_empty) begin
            enter_vld = 1'b1;
            enter_sel = cur_sel;
         end else begin
            go_idle = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         last_served <= 1'b1;
         burst_cnt   <= 4'd0;
         grant       <= GRANT_NONE;
      end else if (enter_vld) begin
         state       <= serve_state(enter_sel);
         grant       <= serve_grant(enter_sel);
         last_served <= enter_sel;
         burst_cnt   <= 4'd0;
      end else if (go_idle) begin
         state <= ST_IDLE;
         grant <= GRANT_NONE;
      end else if (rd_issue) begin
         burst_cnt <= burst_cnt + 4'd1;
      end
   end

   egress_capture #(.DATA_W(DATA_W)) u_capture (
      .clk        (clk),
      .reset      (reset),
      .rd         (rd_issue),
      .src        (read1),
      .fifo0_data (fifo0_data),
      .fifo1_data (fifo1_data),
      .out_data   (out_data),
      .out_src    (out_src),
      .out_valid  (out_valid)
   );
endmodule

// File: tb/tb_egress_arbiter.sv
// Directed and randomized bench for egress_arbiter with behavioural FIFO and word-order models.
module tb_egress_arbiter;
   localparam int BURST = 4;

   typedef logic [7:0] w_q_t[$];
   typedef logic [8:0] e_q_t[$];

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] fifo0_data = 8'h00;
   logic [7:0] fifo1_data = 8'h00;
   logic       fifo0_empty = 1'b1;
   logic       fifo1_empty = 1'b1;
   logic       egress_pause = 1'b0;
   logic       read0, read1, out_src, out_valid;
   logic [7:0] out_data;
   logic [1:0] grant;

   egress_arbiter #(.BURST(BURST), .DATA_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .fifo0_data   (fifo0_data),
      .fifo0_empty  (fifo0_empty),
      .fifo1_data   (fifo1_data),
      .fifo1_empty  (fifo1_empty),
      .egress_pause (egress_pause),
      .read0        (read0),
      .read1        (read1),
      .out_data     (out_data),
      .out_src      (out_src),
      .out_valid    (out_valid),
      .grant        (grant)
   );

   always #5 clk = ~clk;

   w_q_t q0, q1;
   e_q_t got, exp_q;
   int   got_cyc[$];
   int   rd0_cyc[$];
   int   rd1_n;
   int   cyc;
   int   checks;
   int   errors;
   logic ls;
   logic p0, p1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock: sample at negedge, pop the FIFO model just after posedge
   task automatic tick();
      @(negedge clk);
      cyc++;
      chk("read_exclusive", 32'(read0 & read1), 32'd0);
      chk("read0_on_empty", 32'(read0 & fifo0_empty), 32'd0);
      chk("read1_on_empty", 32'(read1 & fifo1_empty), 32'd0);
      p0 = read0;
      p1 = read1;
      if (read0) rd0_cyc.push_back(cyc);
      if (read1) rd1_n++;
      if (out_valid) begin
         got.push_back({out_src, out_data});
         got_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      if (p0 && q0.size() > 0) fifo0_data = q0.pop_front();
      if (p1 && q1.size() > 0) fifo1_data = q1.pop_front();
      fifo0_empty = (q0.size() == 0);
      fifo1_empty = (q1.size() == 0);
   endtask

   task automatic push0(input logic [7:0] d);
      q0.push_back(d);
      fifo0_empty = 1'b0;
   endtask

   task automatic push1(input logic [7:0] d);
      q1.push_back(d);
      fifo1_empty = 1'b0;
   endtask

   task automatic new_case();
      got.delete();
      got_cyc.delete();
      rd0_cyc.delete();
      rd1_n = 0;
      exp_q.delete();
   endtask

   // grant-level model: each grant takes up to BURST words; contention goes to the FIFO not served last
   task automatic model(input w_q_t a, input w_q_t b);
      logic sel;
      int   n;
      while (a.size() > 0 || b.size() > 0) begin
         if (a.size() > 0 && b.size() > 0) sel = !ls;
         else sel = (a.size() == 0);
         ls = sel;
         n = 0;
         while (n < BURST && (sel ? b.size() : a.size()) > 0) begin
            if (sel) exp_q.push_back({1'b1, b.pop_front()});
            else     exp_q.push_back({1'b0, a.pop_front()});
            n++;
         end
      end
   endtask

   task automatic wait_grant(input logic [1:0] want, input string tag);
      int n = 0;
      while (grant == 2'b00 && n < 6) begin
         tick();
         n++;
      end
      chk(tag, 32'(grant), 32'(want));
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < 400) begin
         tick();
         n++;
      end
      chk("drain_timeout", 32'(n < 400), 32'd1);
      repeat (4) tick();
      chk("idle_after_drain", 32'(grant), 32'd0);
   endtask

   task automatic cmp_stream(input string tag);
      chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp_q[i]));
   endtask

   initial begin
      int n;
      int n0;
      int n1;
      checks = 0;
      errors = 0;
      cyc    = 0;
      rd1_n  = 0;
      ls     = 1'b1;

      // reset held with both FIFOs non-empty
      new_case();
      for (int i = 0; i < 5; i++) push0(8'(8'h01 + i));
      for (int i = 0; i < 3; i++) push1(8'(8'h81 + i));
      model(q0, q1);
      repeat (3) begin
         tick();
         chk("rst_read0", 32'(read0), 32'd0);
         chk("rst_read1", 32'(read1), 32'd0);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_out_data", 32'(out_data), 32'd0);
         chk("rst_out_src", 32'(out_src), 32'd0);
         chk("rst_grant", 32'(grant), 32'd0);
      end
      reset = 1'b0;
      wait_grant(2'b01, "first_grant");
      drain();
      cmp_stream("rst_stream");

      // FIFO 0 only, three words
      new_case();
      push0(8'h11); push0(8'h22); push0(8'h33);
      model(q0, q1);
      drain();
      cmp_stream("f0_stream");
      chk("f0_read_count", 32'(rd0_cyc.size()), 32'd3);
      chk("f0_read_consec", 32'(rd0_cyc[2] - rd0_cyc[0]), 32'd2);
      chk("f0_read1_none", 32'(rd1_n), 32'd0);
      chk("f0_latency", 32'(got_cyc[0] - rd0_cyc[0]), 32'd2);
      chk("hold_out_data", 32'(out_data), 32'h33);
      chk("hold_out_src", 32'(out_src), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd0);

      // 10 + 10 words from a fresh reset
      reset = 1'b1;
      new_case();
      repeat (2) tick();
      for (int i = 0; i < 10; i++) begin
         push0(8'(8'h00 + i));
         push1(8'(8'h80 + i));
      end
      ls = 1'b1;
      model(q0, q1);
      reset = 1'b0;
      drain();
      cmp_stream("bal_stream");
      chk("bal_no_bubble", 32'(got_cyc[15] - got_cyc[0]), 32'd15);

      // 12 + 2 words: FIFO 0 burst restarts back to back
      new_case();
      for (int i = 0; i < 12; i++) push0(8'(8'h50 + i));
      push1(8'hA1); push1(8'hA2);
      model(q0, q1);
      drain();
      cmp_stream("skew_stream");
      chk("skew_restart_gap", 32'(got_cyc[13] - got_cyc[6]), 32'd7);

      // pause after the second read of a FIFO 0 burst
      new_case();
      for (int i = 0; i < 8; i++) push0(8'(8'h40 + i));
      n = 0;
      while (rd0_cyc.size() < 2 && n < 10) begin
         tick();
         n++;
      end
      chk("pause_setup_reads", 32'(rd0_cyc.size()), 32'd2);
      egress_pause = 1'b1;
      for (int i = 0; i < 4; i++) push1(8'(8'hC0 + i));
      exp_q.push_back({1'b0, 8'h40});
      exp_q.push_back({1'b0, 8'h41});
      ls = 1'b0;
      model(q0, q1);
      repeat (5) begin
         tick();
         chk("pause_read0", 32'(read0), 32'd0);
         chk("pause_read1", 32'(read1), 32'd0);
      end
      chk("pause_inflight_out", 32'(got.size()), 32'd2);
      chk("pause_grant_idle", 32'(grant), 32'd0);
      egress_pause = 1'b0;
      wait_grant(2'b10, "resume_grant");
      drain();
      cmp_stream("pause_stream");

      // reset during a SERVE1 burst with a read in flight
      new_case();
      for (int i = 0; i < 6; i++) push1(8'(8'hE0 + i));
      n = 0;
      while (rd1_n < 1 && n < 10) begin
         tick();
         n++;
      end
      chk("mid_rst_setup", 32'(rd1_n), 32'd1);
      reset = 1'b1;
      got.delete();
      got_cyc.delete();
      for (int i = 0; i < 3; i++) push0(8'(8'h30 + i));
      ls = 1'b1;
      model(q0, q1);
      repeat (3) begin
         tick();
         chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      end
      chk("mid_rst_dropped", 32'(got.size()), 32'd0);
      reset = 1'b0;
      wait_grant(2'b01, "mid_rst_grant");
      drain();
      cmp_stream("mid_rst_stream");

      // randomized FIFO fills
      for (int it = 0; it < 6; it++) begin
         new_case();
         n0 = $urandom_range(0, 14);
         n1 = $urandom_range(0, 14);
         for (int i = 0; i < n0; i++) push0(8'($urandom));
         for (int i = 0; i < n1; i++) push1(8'($urandom));
         model(q0, q1);
         drain();
         cmp_stream($sformatf("rand%0d", it));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
